// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder cell (two half adders + OR) is reused
// LSB-first across WIDTH cycles, with a carry flip-flop between cycles.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-2:0] ps_q, ps_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             load;
  logic             ha1_s, ha1_c, ha2_c;
  logic             fa_s, fa_c;
  logic [WIDTH-1:0] ps_ext;

  // Shared 1-bit adder cell operating on the current operand LSBs.
  always_comb begin
    ha1_s  = a_q[0] ^ b_q[0];
    ha1_c  = a_q[0] & b_q[0];
    fa_s   = ha1_s ^ c_q;
    ha2_c  = ha1_s & c_q;
    fa_c   = ha1_c | ha2_c;
    ps_ext = {fa_s, ps_q};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    load    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        c_d   = fa_c;
        ps_d  = ps_ext[WIDTH-1:1];
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          sum_d   = ps_ext;
          cout_d  = fa_c;
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Accepted start (from IDLE or DONE) reloads the operand datapath.
    if (load) begin
      a_d   = a;
      b_d   = b;
      c_d   = 1'b0;
      ps_d  = '0;
      cnt_d = '0;
    end

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      ps_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: cycle-level transaction model plus
// directed vectors with hand-computed results.
module tb_serial_adder_ctrl;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks = 0;
  int errors = 0;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op occupies WIDTH busy cycles, then one done cycle with a+b.
  int               rem = 0;
  logic [WIDTH:0]   res = '0;
  logic             exp_busy = 1'b0;
  logic             exp_done = 1'b0;
  logic [WIDTH-1:0] exp_sum = '0;
  logic             exp_cout = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("busy", 32'(busy), 32'd0);
      chk("done", 32'(done), 32'd0);
      chk("sum", 32'(sum), 32'd0);
      chk("cout", 32'(cout), 32'd0);
    end else begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("sum", 32'(sum), 32'(exp_sum));
      chk("cout", 32'(cout), 32'(exp_cout));
    end
    exp_done = 1'b0;
    if (!rst_n) begin
      rem      = 0;
      exp_busy = 1'b0;
      exp_sum  = '0;
      exp_cout = 1'b0;
    end else if (rem > 0) begin
      rem--;
      exp_busy = (rem > 0);
      if (rem == 0) begin
        exp_done = 1'b1;
        exp_sum  = res[WIDTH-1:0];
        exp_cout = res[WIDTH];
      end
    end else if (start) begin
      res      = {1'b0, a} + {1'b0, b};
      rem      = WIDTH;
      exp_busy = 1'b1;
    end else begin
      exp_busy = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits for done; reports negedges elapsed and busy cycles seen.
  task automatic wait_done(output int cycles, output int busy_cnt);
    cycles   = 0;
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      cycles++;
      if (busy) busy_cnt++;
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done expected done within 30 cycles");
  endtask

  task automatic run_op(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                        input logic [WIDTH-1:0] esum, input logic ecout, input string name);
    int cyc, bc;
    a = va;
    b = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bc);
    chk({name, "_sum"}, 32'(sum), 32'(esum));
    chk({name, "_cout"}, 32'(cout), 32'(ecout));
    chk({name, "_latency"}, 32'(cyc), 32'd9);
    chk({name, "_busy_cycles"}, 32'(bc), 32'd8);
    tick();
  endtask

  initial begin
    int cyc, bc;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    rst_n = 1'b1;
    tick();

    run_op(8'h00, 8'h00, 8'h00, 1'b0, "zero");
    run_op(8'hFF, 8'h01, 8'h00, 1'b1, "ripple");
    run_op(8'hA5, 8'h5A, 8'hFF, 1'b0, "alt");
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1, "max");
    run_op(8'h7F, 8'h01, 8'h80, 1'b0, "half");
    tick();
    chk("idle_sum_hold", 32'(sum), 32'h80);

    // Start re-pulse during RUN must be ignored.
    a = 8'h10;
    b = 8'h20;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'h01;
    b = 8'h01;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bc);
    chk("ignore_sum", 32'(sum), 32'h30);
    chk("ignore_cout", 32'(cout), 32'd0);
    chk("ignore_latency", 32'(cyc), 32'd6);
    bc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) bc++;
    end
    chk("ignore_extra_done", 32'(bc), 32'd0);
    tick();

    // Start held through DONE: back-to-back op.
    a = 8'h80;
    b = 8'h80;
    start = 1'b1;
    tick();
    wait_done(cyc, bc);
    chk("b2b_first_sum", 32'(sum), 32'h00);
    chk("b2b_first_cout", 32'(cout), 32'd1);
    tick();
    start = 1'b0;
    wait_done(cyc, bc);
    chk("b2b_second_sum", 32'(sum), 32'h00);
    chk("b2b_second_cout", 32'(cout), 32'd1);
    chk("b2b_second_latency", 32'(cyc), 32'd9);
    chk("b2b_second_busy", 32'(bc), 32'd8);
    tick();

    // Reset mid-RUN aborts the op.
    a = 8'h12;
    b = 8'h34;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(8'h03, 8'h04, 8'h07, 1'b0, "post_reset");
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
